// File: rtl/node_mac_seq.sv
// node_mac_seq: serial multiply-accumulate neuron with a runtime-loadable weight/bias file,
// round-half-down rescale by 2^-FRAC and a saturating ReLU or signed activation.
//
// state | meaning
// IDLE  | waiting for first beat (idx=0); configuration writes accepted
// ACC   | accumulating beats idx=1..N_IN-1
// ROUND | bias add, rescale, round, clamp (exactly one cycle)
// OUT   | result presented until out_ready
module node_mac_seq #(
   parameter int N_IN     = 5,
   parameter int DW       = 8,
   parameter int BW       = 16,
   parameter int FRAC     = 6,
   parameter int ACC_W    = 2*DW + $clog2(N_IN) + 2,
   parameter int ACT_RELU = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    w_we,
   input  logic [$clog2(N_IN)-1:0] w_addr,
   input  logic [DW-1:0]           w_data,
   input  logic                    b_we,
   input  logic [BW-1:0]           b_data,
   output logic                    cfg_err,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DW-1:0]           in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DW-1:0]           out_data,
   output logic                    busy
);
   localparam int IW = $clog2(N_IN);
   localparam int SW = ACC_W + 1;
   localparam logic [IW-1:0]        LAST = IW'(N_IN - 1);
   localparam logic [FRAC-1:0]      HALF = FRAC'(1) << (FRAC - 1);
   localparam logic signed [SW-1:0] MAXV = (SW'(1) << (DW - 1)) - SW'(1);
   localparam logic signed [SW-1:0] MINV = (ACT_RELU != 0) ? SW'(0) : -(SW'(1) << (DW - 1));

   typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;
   state_t state, state_nxt;

   logic [DW-1:0]           w_mem [N_IN];
   logic [DW-1:0]           w_cur;
   logic [BW-1:0]           bias;
   logic [IW-1:0]           idx;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_nxt;
   logic signed [2*DW-1:0]  prod;
   logic signed [SW-1:0]    s;
   logic signed [SW-1:0]    q;
   logic [DW-1:0]           qc;
   logic                    accept;
   logic                    cfg_ok;

   assign accept    = in_valid && in_ready;
   assign cfg_ok    = (state == IDLE);
   assign in_ready  = !reset && (state == IDLE || state == ACC);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);

   // Both operands widened to 2*DW so the product is the exact signed result.
   assign w_cur   = w_mem[idx];
   assign prod    = $signed({{DW{in_data[DW-1]}}, in_data}) * $signed({{DW{w_cur[DW-1]}}, w_cur});
   assign acc_nxt = ((idx == '0) ? '0 : acc) + $signed({{(ACC_W-2*DW){prod[2*DW-1]}}, prod});

   // Floor shift plus round-up only when the dropped fraction is strictly above one half.
   always_comb begin
      s  = $signed({acc[ACC_W-1], acc}) + $signed({{(SW-BW){bias[BW-1]}}, bias});
      q  = s >>> FRAC;
      if (s[FRAC-1:0] > HALF)
         q = q + SW'(1);
      qc = q[DW-1:0];
      if (q > MAXV)
         qc = MAXV[DW-1:0];
      else if (q < MINV)
         qc = MINV[DW-1:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACC: if (accept) state_nxt = (idx == LAST) ? ROUND : ACC;
         ROUND:     state_nxt = OUT;
         OUT:       if (out_ready) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         acc      <= '0;
         bias     <= '0;
         out_data <= '0;
         cfg_err  <= 1'b0;
         for (int i = 0; i < N_IN; i++)
            w_mem[i] <= '0;
      end else begin
         state   <= state_nxt;
         cfg_err <= (w_we || b_we) && !cfg_ok;
         if (accept) begin
            acc <= acc_nxt;
            idx <= (idx == LAST) ? '0 : idx + IW'(1);
         end
         if (state == ROUND)
            out_data <= qc;
         if (cfg_ok && w_we && (w_addr <= LAST))
            w_mem[w_addr] <= w_data;
         if (cfg_ok && b_we)
            bias <= b_data;
      end
   end
endmodule

// File: tb/tb_node_mac_seq.sv
// Scoreboard bench for node_mac_seq: one ReLU and one signed-saturate instance share stimulus,
// expected results come from an integer reference model and are checked by a negedge monitor.
module tb_node_mac_seq;
   localparam int N    = 5;
   localparam int FRAC = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_we, b_we;
   logic [2:0]  w_addr;
   logic [7:0]  w_data;
   logic [15:0] b_data;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        out_ready = 1'b1;

   logic       cfg_err_r, in_ready_r, out_valid_r, busy_r;
   logic [7:0] out_data_r;
   logic       cfg_err_s, in_ready_s, out_valid_s, busy_s;
   logic [7:0] out_data_s;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_beat_cyc = 0;
   int ready_mode = 0;
   int wt [N];
   int cur_in [N];
   int bias_m;
   int exp_r [$];
   int exp_s [$];
   int pv [2] = '{0, 0};
   int pr [2] = '{0, 0};
   int pd [2] = '{0, 0};

   node_mac_seq #(.ACT_RELU(1)) dut_r (
      .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .b_we(b_we), .b_data(b_data), .cfg_err(cfg_err_r), .in_valid(in_valid),
      .in_ready(in_ready_r), .in_data(in_data), .out_valid(out_valid_r),
      .out_ready(out_ready), .out_data(out_data_r), .busy(busy_r));

   node_mac_seq #(.ACT_RELU(0)) dut_s (
      .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .b_we(b_we), .b_data(b_data), .cfg_err(cfg_err_s), .in_valid(in_valid),
      .in_ready(in_ready_s), .in_data(in_data), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_data(out_data_s), .busy(busy_s));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (ready_mode == 0)      out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'b0;
      else                      out_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Real-number definition: s = sum(x*w) + bias, q = floor(s/2^FRAC), bump only if remainder > half.
   function automatic int model(input bit relu);
      int s, m, q, lo;
      s = bias_m;
      for (int i = 0; i < N; i++) s += cur_in[i] * wt[i];
      m = ((s % (1 << FRAC)) + (1 << FRAC)) % (1 << FRAC);
      q = (s - m) / (1 << FRAC);
      if (m > (1 << (FRAC - 1))) q++;
      lo = relu ? 0 : -128;
      if (q > 127) q = 127;
      if (q < lo) q = lo;
      return q;
   endfunction

   task automatic mon(input int k, input logic v, input logic ir, input logic rdy, input logic [7:0] d);
      string tag;
      int dv;
      tag = (k == 0) ? "relu" : "sgn";
      dv  = int'($signed(d));
      if (v) chk($sformatf("%s_in_ready_in_out", tag), int'(ir), 0);
      if (v && pv[k] == 0) chk($sformatf("%s_latency", tag), cyc - last_beat_cyc, 2);
      if (pv[k] != 0 && pr[k] == 0) begin
         if (v) chk($sformatf("%s_hold_data", tag), dv, pd[k]);
         else   chk($sformatf("%s_valid_dropped", tag), 0, 1);
      end
      if (v && rdy) begin
         if (k == 0) begin
            if (exp_r.size() == 0) chk("relu_unexpected_result", 1, 0);
            else                   chk("relu_data", dv, exp_r.pop_front());
         end else begin
            if (exp_s.size() == 0) chk("sgn_unexpected_result", 1, 0);
            else                   chk("sgn_data", dv, exp_s.pop_front());
         end
      end
      pv[k] = int'(v);
      pr[k] = int'(rdy);
      pd[k] = dv;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin pv[k] = 0; pr[k] = 0; pd[k] = 0; end
      end else begin
         mon(0, out_valid_r, in_ready_r, out_ready, out_data_r);
         mon(1, out_valid_s, in_ready_s, out_ready, out_data_s);
      end
   end

   task automatic load_all();
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         w_we = 1'b1; w_addr = 3'(i); w_data = 8'(wt[i]);
         b_we = (i == 0); b_data = 16'(bias_m);
      end
      @(negedge clk);
      w_we = 1'b0; b_we = 1'b0;
   endtask

   task automatic load_bias();
      @(negedge clk);
      b_we = 1'b1; b_data = 16'(bias_m);
      @(negedge clk);
      b_we = 1'b0;
   endtask

   task automatic push_exp();
      exp_r.push_back(model(1'b1));
      exp_s.push_back(model(1'b0));
   endtask

   task automatic send_beat(input int v);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(v);
      while (!(in_ready_r && in_ready_s) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("beat_timeout", 0, 1);
      last_beat_cyc = cyc;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic send_sample(input int gapmax);
      push_exp();
      for (int i = 0; i < N; i++) begin
         send_beat(cur_in[i]);
         if (gapmax > 0) gap($urandom_range(0, gapmax));
      end
      gap(1);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_r.size() != 0 || exp_s.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) chk("drain_timeout", exp_r.size() + exp_s.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      reset = 1'b1; w_we = 1'b0; b_we = 1'b0; w_addr = '0; w_data = '0; b_data = '0;
      in_valid = 1'b0; in_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", int'(out_valid_r), 0);
      chk("rst_in_ready", int'(in_ready_r), 0);
      chk("rst_cfg_err", int'(cfg_err_r), 0);
      chk("rst_busy", int'(busy_r), 0);
      chk("rst_out_data", int'(out_data_r), 0);
      chk("rst_out_data_sgn", int'(out_data_s), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready_r), 1);

      // Reference sample, back-to-back beats.
      wt = '{-16, 14, 2, 62, -38}; bias_m = 512; load_all();
      cur_in = '{10, 20, 30, 40, 50}; send_sample(0); drain();

      // Saturation and ReLU floor.
      cur_in = '{0, 0, 0, 127, -128}; send_sample(0);
      cur_in = '{127, 0, 0, 0, 127};  send_sample(1); drain();

      // Rounding at exact half and just above, negative floor on the signed instance.
      cur_in = '{0, 0, 0, 0, 0};
      bias_m = 544;   load_bias(); send_sample(0); drain();
      bias_m = 545;   load_bias(); send_sample(0); drain();
      bias_m = -1000; load_bias(); send_sample(0); drain();

      // Input gaps plus output backpressure for at least 5 cycles.
      bias_m = 512; load_bias();
      ready_mode = 1;
      cur_in = '{10, 20, 30, 40, 50}; send_sample(3);
      t = 0;
      while (!out_valid_r && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("stall_wait_valid", 0, 1);
      repeat (5) @(negedge clk);
      chk("stall_still_pending", exp_r.size(), 1);
      ready_mode = 0;
      drain();
      repeat (3) @(negedge clk);
      chk("single_result", int'(out_valid_r), 0);

      // Weight write attempted mid-accumulation is dropped and flagged.
      push_exp();
      send_beat(10); send_beat(20);
      @(negedge clk);
      in_valid = 1'b0; w_we = 1'b1; w_addr = 3'd0; w_data = 8'd99;
      @(negedge clk);
      w_we = 1'b0;
      chk("cfg_err_pulse", int'(cfg_err_r), 1);
      chk("busy_in_acc", int'(busy_r), 1);
      @(negedge clk);
      chk("cfg_err_clear", int'(cfg_err_r), 0);
      send_beat(30); send_beat(40); send_beat(50); gap(1); drain();

      // Reset after the third beat wipes partial sum, weights and bias.
      send_beat(10); send_beat(20); send_beat(30);
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("abort_out_valid", int'(out_valid_r), 0);
      chk("abort_in_ready", int'(in_ready_r), 0);
      chk("abort_busy", int'(busy_r), 0);
      reset = 1'b0;
      wt = '{0, 0, 0, 0, 0}; bias_m = 545; load_bias();
      cur_in = '{10, 20, 30, 40, 50}; send_sample(0); drain();
      wt = '{-16, 14, 2, 62, -38}; bias_m = 512; load_all();
      send_sample(0); drain();

      // Randomised samples, two per weight set, with random gaps and backpressure.
      ready_mode = 2;
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < N; i++) wt[i] = int'($urandom_range(0, 255)) - 128;
         bias_m = int'($urandom_range(0, 8000)) - 4000;
         load_all();
         for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < N; i++) cur_in[i] = int'($urandom_range(0, 255)) - 128;
            send_sample(2);
         end
         drain();
      end
      ready_mode = 0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/node_mac_seq.md
Name: node_mac_seq

Overview:
- Parametrised, time-multiplexed successor to the fixed 5-input neuron node.
- Accepts N_IN signed activations serially over a valid/ready stream and multiplies each by a weight from an internal runtime-loadable register file.
- Accumulates at full precision, adds a bias, then rescales by 2^-FRAC with round-half-down and applies a selectable activation (ReLU-saturate or signed-saturate).
- Produces one DW-bit result per sample over a valid/ready output stream; one instance per neuron in the layer wrappers.

Parameters:
- N_IN, 5, number of inputs (weights) per neuron, 2..64
- DW, 8, activation/weight width, signed two's complement
- BW, 16, bias width, signed
- FRAC, 6, fractional shift applied to accumulator before output, 1..2*DW-2
- ACC_W, 2*DW+clog2(N_IN)+2, accumulator width; must exceed all intermediate sums
- ACT_RELU, 1, 1 = ReLU then clamp [0, 2^(DW-1)-1]; 0 = clamp [-2^(DW-1), 2^(DW-1)-1]

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- w_we  in  1  weight write strobe
- w_addr  in  clog2(N_IN)  weight index
- w_data  in  DW  signed weight
- b_we  in  1  bias write strobe
- b_data  in  BW  signed bias
- cfg_err  out  1  one-cycle pulse: write attempted while not IDLE (write dropped)
- in_valid  in  1  activation valid
- in_ready  out  1  block can accept activation
- in_data  in  DW  signed activation
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  signed result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - state=IDLE, idx=0, acc=0
  - all weights=0, bias=0
  - out_valid=0, out_data=0, cfg_err=0, in_ready=0 while reset is asserted
- States:
  - IDLE: idx=0, in_ready=1.
  - ACC: idx in 1..N_IN-1, in_ready=1.
  - ROUND: in_ready=0.
  - OUT: in_ready=0, out_valid=1.
- Accept rule: a beat is accepted when in_valid && in_ready.
  - acc <= (idx==0 ? 0 : acc) + sext(in_data)*sext(w[idx]), computed as a full 2*DW-bit signed product.
  - idx increments on each accepted beat.
  - IDLE->ACC on the first beat; the beat with idx==N_IN-1 moves to ROUND and idx wraps to 0.
  - No beats accepted -> acc and idx hold.
- ROUND (exactly 1 cycle):
  - s = acc + sext(bias).
  - q = s >>> FRAC (arithmetic shift).
  - r = s[FRAC-1:0].
  - If r > 2^(FRAC-1), q = q+1; an exact half is not rounded up.
  - Clamp q per ACT_RELU into out_data; state -> OUT.
- Latency: out_valid rises 2 cycles after the last beat is accepted.
- OUT: out_valid and out_data hold stable until out_ready=1; that cycle -> IDLE and out_valid=0 next cycle. No overlap of the next sample with OUT.
- Configuration writes: w_we/b_we take effect only in IDLE. In any other state the write is dropped and cfg_err pulses for 1 cycle. Simultaneous w_we and b_we in IDLE both apply.
- Reset asserted mid-operation: partial sums are discarded; weights and bias return to 0.
- Width rule: ACC_W sizing guarantees no wrap. The clamp is applied after rounding, so a round-up cannot exceed the clamp limit.

Test Plan:
1. Load weights -16,14,2,62,-38 and bias 512; stream 10,20,30,40,50 back-to-back -> s=1272, out_data=20, out_valid exactly 2 cycles after the 5th beat.
2. Same weights; inputs 0,0,0,127,-128 -> s=13250, out_data=127 (saturation). Inputs 127,0,0,0,127 -> s=-6346, out_data=0 (ReLU).
3. All inputs 0:
   - bias 544 -> out_data=8 (exact half, no round-up)
   - bias 545 -> out_data=9
   - ACT_RELU=0 with bias -1000 -> out_data=-16
4. Handshake stall: insert in_valid gaps between beats and hold out_ready=0 for 5 cycles -> acc unaffected by gaps; out_data stable; in_ready=0 throughout OUT; exactly one result is delivered when out_ready rises.
5. Issue w_we during ACC -> cfg_err pulses, weight unchanged, result identical to scenario 1. Assert reset after the 3rd beat -> out_valid=0, a fresh 5-beat sample with reloaded weights gives the correct result.
